// File: rtl/fft_pkg.sv
// Shared types and constants for the 128-point radix-2 DIT FFT control path.
package fft_pkg;

    localparam int N          = 128;
    localparam int LOG2N      = 7;
    localparam int BF_LATENCY = 3;
    localparam int STAGE_W    = 3;
    localparam int K_W        = LOG2N - 1;

    typedef logic [LOG2N-1:0]   addr_t;
    typedef logic [LOG2N-2:0]   tw_t;
    typedef logic [K_W-1:0]     k_t;
    typedef logic [STAGE_W-1:0] stage_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_e;

    // One slot of the write-back delay line.
    typedef struct packed {
        logic  valid;
        addr_t addr_a;
        addr_t addr_b;
    } wr_slot_t;

endpackage

// File: rtl/fft_addr_gen.sv
// Butterfly operand addresses and twiddle index for stage s, butterfly k.
// Purely combinational so the readout path can share it.
module fft_addr_gen
    import fft_pkg::*;
(
    input  logic [STAGE_W-1:0] s,
    input  logic [K_W-1:0]     k,
    output logic [LOG2N-1:0]   addr_a,
    output logic [LOG2N-1:0]   addr_b,
    output logic [LOG2N-2:0]   tw_idx
);

    addr_t half;
    addr_t pos;
    addr_t grp;
    addr_t k_ext;
    logic [STAGE_W:0] s_p1;
    stage_t tw_shift;

    // Insert a zero at bit s of k to get the top operand; twiddle scales pos up to N/2.
    always_comb begin
        k_ext    = addr_t'(k);
        s_p1     = {1'b0, s} + {{STAGE_W{1'b0}}, 1'b1};
        tw_shift = stage_t'(LOG2N - 1) - s;
        half     = addr_t'(1) << s;
        pos      = k_ext & (half - addr_t'(1));
        grp      = k_ext >> s;
        addr_a   = (grp << s_p1) | pos;
        addr_b   = addr_a + half;
        tw_idx   = tw_t'(pos << tw_shift);
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Stage/butterfly sequencer for the in-place 128-point FFT core.
//
// state | meaning
// IDLE  | waiting for a full sample buffer (start)
// ISSUE | one butterfly read per cycle, k = 0..N/2-1
// DRAIN | BF_LATENCY cycles so the last writes land before the next stage reads
// DONE  | one-cycle done pulse, start ignored
module fft_stage_sequencer #(
    parameter int BF_LATENCY = fft_pkg::BF_LATENCY
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     start,
    output logic                     rd_en,
    output logic [fft_pkg::LOG2N-1:0] rd_addr_a,
    output logic [fft_pkg::LOG2N-1:0] rd_addr_b,
    output logic [fft_pkg::LOG2N-2:0] tw_idx,
    output logic                     wr_en,
    output logic [fft_pkg::LOG2N-1:0] wr_addr_a,
    output logic [fft_pkg::LOG2N-1:0] wr_addr_b,
    output logic [2:0]               stage,
    output logic                     busy,
    output logic                     done
);
    import fft_pkg::*;

    localparam int DRAIN_W = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
    localparam k_t     K_LAST     = k_t'(N / 2 - 1);
    localparam stage_t STAGE_LAST = stage_t'(LOG2N - 1);

    seq_state_e state_q, state_d;
    k_t         k_q, k_d;
    stage_t     stage_q, stage_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;

    addr_t gen_a;
    addr_t gen_b;
    tw_t   gen_tw;

    wr_slot_t pipe_q [BF_LATENCY];

    fft_addr_gen u_addr_gen (
        .s      (stage_q),
        .k      (k_q),
        .addr_a (gen_a),
        .addr_b (gen_b),
        .tw_idx (gen_tw)
    );

    // State, butterfly counter, drain down-counter and stage register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            stage_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            stage_q <= stage_d;
            drain_q <= drain_d;
        end
    end

    // Next-state logic and read-side outputs.
    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        rd_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    stage_d = '0;
                end
            end
            ISSUE: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = DRAIN;
                    k_d     = '0;
                    drain_d = DRAIN_W'(BF_LATENCY - 1);
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q == '0) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = ISSUE;
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Addresses are forced to zero outside ISSUE so idle outputs stay quiet.
        rd_addr_a = rd_en ? gen_a  : '0;
        rd_addr_b = rd_en ? gen_b  : '0;
        tw_idx    = rd_en ? gen_tw : '0;
    end

    // Write-back delay line: read request re-emerges BF_LATENCY cycles later.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= '{valid: rd_en, addr_a: rd_addr_a, addr_b: rd_addr_b};
            for (int i = 1; i < BF_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    // Write-side outputs come straight from the last delay slot.
    always_comb begin
        wr_en     = pipe_q[BF_LATENCY-1].valid;
        wr_addr_a = pipe_q[BF_LATENCY-1].addr_a;
        wr_addr_b = pipe_q[BF_LATENCY-1].addr_b;
        stage     = stage_q;
    end

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer (default latency plus a BF_LATENCY=1 instance).
module tb_fft_stage_sequencer;

    localparam int TN      = 128;
    localparam int TL      = 3;
    localparam int TSTAGES = 7;

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
    } exp_t;

    logic       clk;
    logic       n_rst;
    logic       start;
    logic       rd_en;
    logic [6:0] rd_addr_a;
    logic [6:0] rd_addr_b;
    logic [5:0] tw_idx;
    logic       wr_en;
    logic [6:0] wr_addr_a;
    logic [6:0] wr_addr_b;
    logic [2:0] stage;
    logic       busy;
    logic       done;

    logic       start1;
    logic       rd_en1;
    logic [6:0] rd_addr_a1;
    logic [6:0] rd_addr_b1;
    logic [5:0] tw_idx1;
    logic       wr_en1;
    logic [6:0] wr_addr_a1;
    logic [6:0] wr_addr_b1;
    logic [2:0] stage1;
    logic       busy1;
    logic       done1;

    int   edge_cnt = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    exp_t q_rd[$];
    exp_t q_wr[$];
    int   q_done[$];
    int   pending[128];
    int   wr_hits[8][128];
    exp_t mon_e;
    int   mon_d;
    int   mon_bad;

    fft_stage_sequencer u_dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_idx    (tw_idx),
        .wr_en     (wr_en),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b),
        .stage     (stage),
        .busy      (busy),
        .done      (done)
    );

    fft_stage_sequencer #(.BF_LATENCY(1)) u_dut_l1 (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start1),
        .rd_en     (rd_en1),
        .rd_addr_a (rd_addr_a1),
        .rd_addr_b (rd_addr_b1),
        .tw_idx    (tw_idx1),
        .wr_en     (wr_en1),
        .wr_addr_a (wr_addr_a1),
        .wr_addr_b (wr_addr_b1),
        .stage     (stage1),
        .busy      (busy1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
        end
    endtask

    function automatic int outs_nz();
        return int'(rd_en) + int'(rd_addr_a != 7'd0) + int'(rd_addr_b != 7'd0)
             + int'(tw_idx != 6'd0) + int'(wr_en) + int'(wr_addr_a != 7'd0)
             + int'(wr_addr_b != 7'd0) + int'(stage != 3'd0) + int'(busy) + int'(done);
    endfunction

    function automatic int outs1_nz();
        return int'(rd_en1) + int'(rd_addr_a1 != 7'd0) + int'(rd_addr_b1 != 7'd0)
             + int'(tw_idx1 != 6'd0) + int'(wr_en1) + int'(wr_addr_a1 != 7'd0)
             + int'(wr_addr_b1 != 7'd0) + int'(stage1 != 3'd0) + int'(busy1) + int'(done1);
    endfunction

    // Expected transform: stage s pairs every address with bit s clear, in ascending order.
    task automatic push_run(input int base);
        exp_t e;
        int   k;
        int   half;
        for (int s = 0; s < TSTAGES; s++) begin
            half = 1 << s;
            k = 0;
            for (int a = 0; a < TN; a++) begin
                if (((a >> s) & 1) == 0) begin
                    e.cyc = base + 1 + s * (TN / 2 + TL) + k;
                    e.a   = a;
                    e.b   = a + half;
                    e.tw  = (a % half) << (TSTAGES - 1 - s);
                    e.st  = s;
                    q_rd.push_back(e);
                    e.cyc = e.cyc + TL;
                    q_wr.push_back(e);
                    k++;
                end
            end
        end
        q_done.push_back(base + 470);
    endtask

    task automatic flush_model();
        q_rd.delete();
        q_wr.delete();
        q_done.delete();
        for (int i = 0; i < 128; i++) begin
            pending[i] = 0;
            for (int s = 0; s < 8; s++) wr_hits[s][i] = 0;
        end
    endtask

    // Monitor: compares every DUT read, write and done against the scoreboard.
    always @(negedge clk) begin
        if (mon_en && n_rst) begin
            if (rd_en) begin
                if (q_rd.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    mon_e = q_rd.pop_front();
                    check("rd_cycle", edge_cnt, mon_e.cyc);
                    check("rd_addr_a", int'(rd_addr_a), mon_e.a);
                    check("rd_addr_b", int'(rd_addr_b), mon_e.b);
                    check("tw_idx", int'(tw_idx), mon_e.tw);
                    check("rd_stage", int'(stage), mon_e.st);
                end
                check("raw_hazard_a", pending[rd_addr_a], 0);
                check("raw_hazard_b", pending[rd_addr_b], 0);
                pending[rd_addr_a]++;
                pending[rd_addr_b]++;
            end
            if (wr_en) begin
                if (q_wr.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    mon_e = q_wr.pop_front();
                    check("wr_cycle", edge_cnt, mon_e.cyc);
                    check("wr_addr_a", int'(wr_addr_a), mon_e.a);
                    check("wr_addr_b", int'(wr_addr_b), mon_e.b);
                end
                if (pending[wr_addr_a] > 0) pending[wr_addr_a]--;
                if (pending[wr_addr_b] > 0) pending[wr_addr_b]--;
                wr_hits[stage][wr_addr_a]++;
                wr_hits[stage][wr_addr_b]++;
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    check("done_unexpected", 1, 0);
                end else begin
                    mon_d = q_done.pop_front();
                    check("done_cycle", edge_cnt, mon_d);
                end
                check("busy_at_done", int'(busy), 0);
                for (int s = 0; s < TSTAGES; s++) begin
                    mon_bad = 0;
                    for (int i = 0; i < TN; i++) begin
                        if (wr_hits[s][i] != 1) mon_bad++;
                        wr_hits[s][i] = 0;
                    end
                    check("stage_write_cover", mon_bad, 0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", edge_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int wr_seen;
        int done_cnt;
        int rdc;
        int wrc;

        n_rst  = 1'b0;
        start  = 1'b0;
        start1 = 1'b0;
        flush_model();

        repeat (10) begin
            @(negedge clk);
            check("reset_outputs", outs_nz(), 0);
            check("reset_outputs_l1", outs1_nz(), 0);
        end
        @(negedge clk);
        n_rst  = 1'b1;
        mon_en = 1'b1;

        // Run A with ignored pulses at 50 and 470, then run B launched at 471.
        @(negedge clk);
        base = edge_cnt;
        push_run(base);
        start = 1'b1;
        for (int n = 1; n <= 472; n++) begin
            @(negedge clk);
            start = (n == 50 || n == 470 || n == 471);
            if (n == 471) push_run(edge_cnt);
            if (n == 1) begin
                check("first_busy", int'(busy), 1);
                check("first_rd_a", int'(rd_addr_a), 0);
                check("first_rd_b", int'(rd_addr_b), 1);
            end
            if (n == 6) begin
                check("s0k5_a", int'(rd_addr_a), 10);
                check("s0k5_b", int'(rd_addr_b), 11);
                check("s0k5_tw", int'(tw_idx), 0);
            end
            if (n == 211) begin
                check("s3k9_a", int'(rd_addr_a), 17);
                check("s3k9_b", int'(rd_addr_b), 25);
                check("s3k9_tw", int'(tw_idx), 8);
                check("s3k9_stage", int'(stage), 3);
            end
            if (n == 466) begin
                check("s6k63_a", int'(rd_addr_a), 63);
                check("s6k63_b", int'(rd_addr_b), 127);
                check("s6k63_tw", int'(tw_idx), 63);
            end
            if (n == 469) check("busy_last_drain", int'(busy), 1);
            if (n == 470) check("done_at_470", int'(done), 1);
        end
        start = 1'b0;

        // Run B started at rel 471; abandon it mid-stage 3 (its rel cycle 222).
        base = base + 471;
        while (edge_cnt < base + 222) @(negedge clk);
        check("midrun_wr_in_flight", int'(wr_en), 1);
        #2;
        n_rst = 1'b0;
        #1;
        check("async_reset_outputs", outs_nz(), 0);
        flush_model();
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        wr_seen = 0;
        repeat (10) begin
            @(negedge clk);
            wr_seen += int'(wr_en);
        end
        check("no_wr_after_reset", wr_seen, 0);

        // Run C after reset must complete normally.
        @(negedge clk);
        base = edge_cnt;
        push_run(base);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (475) @(negedge clk);

        // BF_LATENCY=1 instance.
        @(negedge clk);
        start1   = 1'b1;
        done_cnt = 0;
        rdc      = 0;
        wrc      = 0;
        for (int n = 1; n <= 460; n++) begin
            @(negedge clk);
            start1 = 1'b0;
            rdc += int'(rd_en1);
            wrc += int'(wr_en1);
            if (done1) begin
                done_cnt++;
                check("l1_done_cycle", n, 456);
            end
            for (int s = 0; s < TSTAGES - 1; s++) begin
                if (n == 64 + 65 * s) check("l1_last_issue", int'(rd_en1), 1);
                if (n == 65 + 65 * s) check("l1_gap_idle", int'(rd_en1), 0);
                if (n == 66 + 65 * s) check("l1_next_issue", int'(rd_en1), 1);
            end
        end
        check("l1_done_count", done_cnt, 1);
        check("l1_rd_count", rdc, 448);
        check("l1_wr_count", wrc, 448);

        check("rd_queue_drained", q_rd.size(), 0);
        check("wr_queue_drained", q_wr.size(), 0);
        check("done_queue_drained", q_done.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for the in-place 128-point radix-2 DIT FFT core. It starts when the serial front end reports a full, bit-reverse-ordered sample buffer. It then steps through all 7 butterfly stages, issuing read addresses, twiddle indices and delayed write-back addresses to the butterfly datapath and sample RAM. It pulses `done` when the final stage has been written back and the spectrum can be read out.

## Interface
- `N`, 128: transform length, power of two.
- `LOG2N`, 7: log2(N), number of stages.
- `BF_LATENCY`, 3: cycles from `rd_en` to the butterfly result being writable; must be ≥1.

- `clk`  in  1  system clock; all logic on rising edge.
- `n_rst`  in  1  reset, asynchronous and active-low.
- `start`  in  1  one-cycle request from the serial front end: buffer full.
- `rd_en`  out  1  read the butterfly operand pair this cycle.
- `rd_addr_a`  out  LOG2N  top operand address.
- `rd_addr_b`  out  LOG2N  bottom operand address.
- `tw_idx`  out  LOG2N-1  twiddle ROM index, W_N^tw_idx.
- `wr_en`  out  1  write the butterfly results this cycle.
- `wr_addr_a`  out  LOG2N  write address for the top result.
- `wr_addr_b`  out  LOG2N  write address for the bottom result.
- `stage`  out  3  current stage, 0..LOG2N-1; also drives the datapath scaling shift.
- `busy`  out  1  high from the first issue cycle through the final drain cycle.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- States and transitions:
  - IDLE: `start` → ISSUE, with s=0 and k=0.
  - ISSUE: issues butterfly k each cycle. At k=N/2-1 → DRAIN.
  - DRAIN: waits BF_LATENCY cycles. On exit, goes to ISSUE with s+1 and k=0, or to DONE if s=LOG2N-1.
  - DONE: lasts one cycle, then → IDLE.
- Address rule for stage s and butterfly k (0..N/2-1):
  - half = 1<<s.
  - pos = k & (half-1).
  - grp = k >> s.
  - rd_addr_a = (grp << (s+1)) | pos.
  - rd_addr_b = rd_addr_a + half.
  - tw_idx = pos << (LOG2N-1-s).
- All arithmetic is unsigned and truncated to the port width. No wrap-around is possible inside one stage.
- Write path: a BF_LATENCY-deep shift register holds {valid, addr_a, addr_b}. `wr_en`, `wr_addr_a` and `wr_addr_b` are the rd_* values delayed by exactly BF_LATENCY cycles. The transform is in place, so write addresses equal read addresses.
- DRAIN exists to prevent read-after-write hazards across stages. The first read of stage s+1 comes one cycle after the last write of stage s.
- `start` while busy, or in DONE, is ignored. It is not queued.
- `n_rst` low at any time:
  - FSM returns to IDLE.
  - Counters clear.
  - Write pipeline valids clear, so no stray `wr_en` after reset.
  - Any partial transform is abandoned.
- Reset values: all outputs 0. `stage` is 0.

## Timing
- `start` sampled high at edge 0. First `rd_en` is in cycle 1, with addresses (0,1) and `tw_idx` 0.
- Stage s issues during cycles 1+s·(N/2+BF_LATENCY) … +N/2-1. The following BF_LATENCY cycles are drain.
- `rd_en` is continuous during ISSUE and low during DRAIN.
- `wr_en` carries exactly N/2 pulses per stage.
- `done` is high in cycle 1+LOG2N·(N/2+BF_LATENCY): cycle 470 for the defaults. `busy` falls in that same cycle.
- A new `start` is accepted in the cycle after `done`, at the earliest.
- `stage` changes on the first ISSUE cycle of the new stage. It stays valid through that stage's drain.

## Structure
- Shared package `fft_pkg`:
  - N, LOG2N, BF_LATENCY.
  - `addr_t` (logic [LOG2N-1:0]) and `tw_t`.
  - `seq_state_e` {IDLE, ISSUE, DRAIN, DONE}.
- One sub-module, `fft_addr_gen`: purely combinational (s, k) → (addr_a, addr_b, tw_idx). It is reused by the readout logic.
- The top level holds the FSM, the k counter, the drain counter, the stage register and the write delay line.

## Test plan
- Reset with `start` held low for 10 cycles → all outputs 0; `rd_en` and `wr_en` never assert.
- Single `start` pulse → stage 0 k=5 reads (10,11) with tw 0; stage 3 k=9 reads (17,25) with tw 8; stage 6 k=63 reads (63,127) with tw 63. `done` occurs at cycle 470.
- Full run scoreboard → each stage writes every address 0..127 exactly once. Every `wr_addr` equals the `rd_addr` from exactly BF_LATENCY cycles earlier. There is no read of any address in the BF_LATENCY cycles before its pending write.
- `start` pulsed at cycles 50 and 470 → both pulses ignored; exactly one `done`; `start` at cycle 471 launches a second transform.
- `n_rst` asserted asynchronously mid-stage 3 while writes are in flight → outputs clear immediately; no `wr_en` after release. A subsequent `start` completes normally with `done` 470 cycles later.
- Run with BF_LATENCY=1 → `done` at cycle 456; adjacent stages have exactly one idle cycle between their issue phases.
